// File: rtl/fifo_drain_checker.sv
// ---------------------------------------------------------------------------
// fifo_drain_checker
//
// Consumer stage sitting directly after the small producer->consumer FIFO.
// It pulls one word out of the FIFO every RATE cycles while the FIFO has
// data. Each word is presented with a one-cycle valid pulse and checked
// against the producer's count-by-one sequence. Saturating word and error
// counters are kept for the monitor.
//
// Ports:
//   clk           in   system clock, everything on the rising edge
//   rst_n         in   asynchronous active-low reset
//   enable        in   low blocks new reads (an in-flight read still finishes)
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_req
//   fifo_rd_req   out  one-cycle read strobe, decoded straight from state
//   data_out      out  last word consumed
//   data_valid    out  one-cycle pulse when data_out updates
//   seq_err       out  pulse alongside data_valid on a sequence mismatch
//   stall         out  pacing expired but FIFO empty or enable low
//   word_count    out  words consumed, saturating
//   err_count     out  sequence errors, saturating
// ---------------------------------------------------------------------------
module fifo_drain_checker #(
    parameter int DATA_W = 4,
    parameter int RATE   = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_req,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              seq_err,
    output logic              stall,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count
);

    // The pacing counter only ever holds values up to RATE-3.
    localparam int PACE_W = $clog2(RATE);
    // WAIT spends RATE-2 cycles counting down, plus READ and CAPTURE, so a
    // reload of RATE-3 gives exactly one read every RATE cycles.
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(RATE - 3);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PACE_W-1:0]  paceCnt_q, paceCnt_d;
    logic               capture;
    logic               mismatch;
    logic               first_q, first_d;
    logic [DATA_W-1:0]  expected_q, expected_d;
    logic [DATA_W-1:0]  dataOut_q, dataOut_d;
    logic               dataValid_q, dataValid_d;
    logic               seqErr_q, seqErr_d;
    logic [CNT_W-1:0]   wordCount_q, wordCount_d;
    logic [CNT_W-1:0]   errCount_q, errCount_d;

    // Next-state logic for the read sequencer. WAIT counts the pacing
    // interval down and then either launches a read or reports a stall.
    // READ and CAPTURE run unconditionally, so a read once launched always
    // completes regardless of enable or the empty flag.
    always_comb begin
        state_d   = state_q;
        paceCnt_d = paceCnt_q;
        stall     = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (paceCnt_q != '0) begin
                    paceCnt_d = paceCnt_q - 1'b1;
                end else if (enable && !fifo_empty) begin
                    state_d = S_READ;
                end else begin
                    stall = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d   = S_WAIT;
                paceCnt_d = PACE_RELOAD;
                capture   = 1'b1;
            end
            default: begin
                state_d   = S_WAIT;
                paceCnt_d = PACE_RELOAD;
            end
        endcase
    end

    // Capture and sequence check. The first word after reset only seeds the
    // expected value. The expected value always follows the word actually
    // seen, so a dropped word costs exactly one error and then resyncs.
    always_comb begin
        mismatch    = capture && !first_q && (fifo_rd_data != expected_q);
        first_d     = capture ? 1'b0 : first_q;
        expected_d  = capture ? (fifo_rd_data + 1'b1) : expected_q;
        dataOut_d   = capture ? fifo_rd_data : dataOut_q;
        dataValid_d = capture;
        seqErr_d    = mismatch;
        wordCount_d = wordCount_q;
        errCount_d  = errCount_q;
        if (capture && (wordCount_q != CNT_MAX)) begin
            wordCount_d = wordCount_q + 1'b1;
        end
        if (mismatch && (errCount_q != CNT_MAX)) begin
            errCount_d = errCount_q + 1'b1;
        end
    end

    // All state registers. Reset abandons any in-flight read outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            paceCnt_q   <= PACE_RELOAD;
            first_q     <= 1'b1;
            expected_q  <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            seqErr_q    <= 1'b0;
            wordCount_q <= '0;
            errCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            paceCnt_q   <= paceCnt_d;
            first_q     <= first_d;
            expected_q  <= expected_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            seqErr_q    <= seqErr_d;
            wordCount_q <= wordCount_d;
            errCount_q  <= errCount_d;
        end
    end

    assign fifo_rd_req = (state_q == S_READ);
    assign data_out    = dataOut_q;
    assign data_valid  = dataValid_q;
    assign seq_err     = seqErr_q;
    assign word_count  = wordCount_q;
    assign err_count   = errCount_q;

endmodule
